ff_bank_arbiter: RTL and testbench
==================================

FF_BANK_ARBITER -- requirements
Module: ff_bank_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8: data width of each bank word.
REQ-003 Parameter DEPTH, default 4: number of bank words (power of 2); AW = $clog2(DEPTH).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, named as follows:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  synchronous active-high reset.
REQ-005 Requester and bank ports SHALL be:
- req  input  N_REQ  per-requester access request.
- lock  input  N_REQ  per-requester hold-grant request.
- we  input  N_REQ  per-requester write enable (0 = read).
- addr  input  N_REQ*AW  packed per-requester word addresses.
- wdata  input  N_REQ*WIDTH  packed per-requester write data.
- gnt  output  N_REQ  one-hot grant, registered.
- rdata  output  WIDTH  read data of the granted access.
- rvalid  output  1  rdata valid strobe.
- busy  output  1  high in state GRANT.

Function
REQ-006 The FSM SHALL have two states: IDLE and GRANT.
REQ-007 In IDLE with req != 0, the block SHALL select a winner round-robin, starting the search at pointer ptr, and enter GRANT with gnt = onehot(winner) on the next edge.
REQ-008 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0.
REQ-009 In GRANT, on each edge the winner's we/addr/wdata SHALL be applied to the bank:
- we = 1: word[addr] <= wdata.
- we = 0: read of word[addr].
REQ-010 In GRANT, if lock[winner] = 1, the block SHALL remain in GRANT and keep gnt unchanged, performing one access per cycle.
REQ-011 In GRANT, if lock[winner] = 0, the block SHALL return to IDLE, clear gnt, and set ptr = (winner+1) mod N_REQ.
REQ-012 Deassertion of req[winner] during GRANT SHALL be ignored; only lock controls the hold.
REQ-013 Throughput SHALL be one access per 2 cycles unlocked and one access per cycle locked.
REQ-014 Writes to words not addressed SHALL leave them unchanged; read-only accesses SHALL modify no word.
REQ-015 rvalid SHALL pulse for each read access; rdata SHALL hold its last value when rvalid = 0.
REQ-016 busy SHALL equal (state == GRANT).

Reset
REQ-017 With clr = 1 at an edge, the block SHALL set state = IDLE, gnt = 0, ptr = 0, all bank words = 0, rdata = 0 and rvalid = 0, overriding any access in progress, including a locked GRANT.
REQ-018 The first arbitration after clr deasserts SHALL start the round-robin search at requester 0.

Configuration
REQ-019 With macro FF_BANK_RDATA_REG_EN defined:
- rdata/rvalid SHALL be registered, appearing 1 cycle after the read edge.
- Read-after-write to the same word in consecutive locked cycles SHALL return the new data.
REQ-020 Without FF_BANK_RDATA_REG_EN:
- rdata = word[addr of winner] combinationally during GRANT.
- rvalid = busy & ~we[winner].

Structure
REQ-021 Package ff_bank_pkg SHALL hold the state enum (IDLE, GRANT) and the default parameter constants.
REQ-022 Each bank word SHALL be an instance of sub-module ff_bank_word: WIDTH-bit register with sync clr and ena, where ena = write-selected for that word.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- clr=1 mid-GRANT with lock[1]=1 -> next cycle gnt=0, busy=0, all words 0.
- req=4'b1111 with lock=0 held 8 grant rounds -> gnt sequence 0001,0010,0100,1000,0001,...
- Requester 2 writes 8'hA5 to addr 3, then requester 0 reads addr 3 -> rdata=8'hA5 with rvalid, latency per the FF_BANK_RDATA_REG_EN setting.
- lock[0]=1 for 3 cycles with req=4'b1001 -> gnt=0001 for 3 cycles, then 1000 after one IDLE cycle.
- Requester 1 performs locked writes of 1,2,3 to addr 0,1,2 on consecutive cycles -> words = 1,2,3 and word 3 unchanged.
- req=0 for 5 cycles after reset -> state stays IDLE, gnt=0, rvalid=0.

Source files
------------

// File: rtl/ff_bank_pkg.sv
// ----------------------------------------------------------------------------
// ff_bank_pkg
// Shared definitions for the banked-register arbiter:
//   - state_t      : arbiter FSM states (IDLE, GRANT)
//   - DEF_N_REQ    : default number of requesters
//   - DEF_WIDTH    : default bank word width
//   - DEF_DEPTH    : default number of bank words
// Optional build macro used by the arbiter: FF_BANK_RDATA_REG_EN
// ----------------------------------------------------------------------------
package ff_bank_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

endpackage : ff_bank_pkg

// File: rtl/ff_bank_word.sv
// ----------------------------------------------------------------------------
// ff_bank_word
// One storage word of the bank: a WIDTH-bit register with synchronous clear
// and load enable.
// Ports:
//   clk  in   clock
//   clr  in   synchronous active-high clear (word -> 0)
//   ena  in   load enable (this word is the target of a write)
//   d    in   WIDTH  data to load
//   q    out  WIDTH  stored word
// ----------------------------------------------------------------------------
module ff_bank_word
    import ff_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ena,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (ena) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : ff_bank_word

// File: rtl/ff_bank_arbiter.sv
// ----------------------------------------------------------------------------
// ff_bank_arbiter
// Round-robin arbiter in front of a small register bank. One requester at a
// time owns the bank; an unlocked grant performs a single access and returns
// to IDLE, a locked grant keeps ownership and performs one access per cycle.
// Ports:
//   clk     in   clock
//   clr     in   synchronous active-high reset
//   req     in   N_REQ        per-requester access request
//   lock    in   N_REQ        per-requester hold-grant request
//   we      in   N_REQ        per-requester write enable (0 = read)
//   addr    in   N_REQ*AW     packed per-requester word addresses
//   wdata   in   N_REQ*WIDTH  packed per-requester write data
//   gnt     out  N_REQ        one-hot registered grant
//   rdata   out  WIDTH        read data of the granted access
//   rvalid  out  1            rdata valid strobe
//   busy    out  1            high while in GRANT
// Build option: define FF_BANK_RDATA_REG_EN to register rdata/rvalid (one
// cycle after the read edge); otherwise they are combinational during GRANT.
// ----------------------------------------------------------------------------
module ff_bank_arbiter
    import ff_bank_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ-1:0]       we,
    input  logic [N_REQ*AW-1:0]    addr,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rvalid,
    output logic                   busy
);

    state_t            r_state;
    logic [PW-1:0]     r_winner;
    logic [PW-1:0]     r_ptr;
    logic [N_REQ-1:0]  r_gnt;

    logic [AW-1:0]     w_addr_arr  [N_REQ];
    logic [WIDTH-1:0]  w_wdata_arr [N_REQ];
    logic [WIDTH-1:0]  w_word_q    [DEPTH];

    logic [AW-1:0]     w_addr_win;
    logic [WIDTH-1:0]  w_wdata_win;
    logic              w_we_win;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic [WIDTH-1:0]  w_rd_word;

    logic              w_found;
    logic [PW-1:0]     w_pick;

    // Unpack the per-requester buses so the winner can be selected by index.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = addr[gi*AW +: AW];
            assign w_wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The winner's controls are sampled live on every GRANT cycle, so a
    // locked owner can stream different addresses/data each cycle.
    assign w_addr_win  = w_addr_arr[r_winner];
    assign w_wdata_win = w_wdata_arr[r_winner];
    assign w_we_win    = we[r_winner];
    assign w_wr_fire   = (r_state == GRANT) &&  w_we_win;
    assign w_rd_fire   = (r_state == GRANT) && !w_we_win;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_bank
            ff_bank_word #(
                .WIDTH (WIDTH)
            ) u_word (
                .clk (clk),
                .clr (clr),
                .ena (w_wr_fire && (w_addr_win == AW'(gi))),
                .d   (w_wdata_win),
                .q   (w_word_q[gi])
            );
        end
    endgenerate

    assign w_rd_word = w_word_q[w_addr_win];

    // Round-robin search: first requester at or after r_ptr, wrapping.
    always_comb begin
        logic [PW:0] v_idx;
        w_found = 1'b0;
        w_pick  = r_ptr;
        v_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            v_idx = {1'b0, r_ptr} + (PW+1)'(i);
            if (v_idx >= (PW+1)'(N_REQ)) begin
                v_idx = v_idx - (PW+1)'(N_REQ);
            end
            if (!w_found && req[v_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = v_idx[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_ptr    <= '0;
            r_winner <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state  <= GRANT;
                        r_winner <= w_pick;
                        r_gnt    <= N_REQ'(1) << w_pick;
                    end else begin
                        r_gnt    <= '0;
                    end
                end
                GRANT: begin
                    // Only lock holds the grant; dropping req is ignored.
                    if (!lock[r_winner]) begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_ptr   <= (r_winner == PW'(N_REQ-1)) ? '0 : r_winner + PW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign busy = (r_state == GRANT);

`ifdef FF_BANK_RDATA_REG_EN
    logic [WIDTH-1:0] r_rdata;
    logic             r_rvalid;

    // Captured at the read edge; a write one cycle earlier is already in
    // the word, so back-to-back locked write/read returns the new value.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
`else
    logic [WIDTH-1:0] r_rdata_hold;

    // Remembers the last read so rdata holds steady while rvalid is low.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_rdata_hold <= '0;
        end else if (w_rd_fire) begin
            r_rdata_hold <= w_rd_word;
        end
    end

    assign rvalid = w_rd_fire;
    assign rdata  = w_rd_fire ? w_rd_word : r_rdata_hold;
`endif

endmodule : ff_bank_arbiter

// File: tb/tb_ff_bank_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ff_bank_arbiter
// Self-checking bench for ff_bank_arbiter (default parameters). Directed
// sequences, a table of grant vectors, and a randomized phase compared
// against a behavioural model of the arbiter and bank.
// ----------------------------------------------------------------------------
module tb_ff_bank_arbiter;

    localparam int N = 4;

    logic        clk;
    logic        clr;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [3:0]  we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        busy;

    ff_bank_arbiter dut (
        .clk    (clk),
        .clr    (clr),
        .req    (req),
        .lock   (lock),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rdata  (rdata),
        .rvalid (rvalid),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: owner (-1 = nobody), pointer, memory, read history.
    int         m_h;
    int         m_ptr;
    logic [7:0] m_mem [4];
    logic [7:0] m_hold;
    logic       m_rv;
    logic [7:0] m_rd;

    typedef struct {
        logic       clr;
        logic [3:0] req;
        logic [3:0] lock;
        logic [3:0] exp_gnt;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [24];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_acc(input int r, input logic w, input logic [1:0] a, input logic [7:0] d);
        we[r]          = w;
        addr[r*2 +: 2] = a;
        wdata[r*8 +: 8] = d;
    endtask

    task automatic model_step();
        if (clr) begin
            m_h   = -1;
            m_ptr = 0;
            for (int k = 0; k < 4; k++) m_mem[k] = 8'h00;
            m_hold = 8'h00;
            m_rv   = 1'b0;
            m_rd   = 8'h00;
        end else if (m_h < 0) begin
            m_rv = 1'b0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (req[c]) begin
                    m_h = c;
                    break;
                end
            end
        end else begin
            int a;
            a = int'(addr[m_h*2 +: 2]);
            if (we[m_h]) begin
                m_mem[a] = wdata[m_h*8 +: 8];
                m_rv     = 1'b0;
            end else begin
                m_hold = m_mem[a];
                m_rd   = m_mem[a];
                m_rv   = 1'b1;
            end
            if (!lock[m_h]) begin
                m_ptr = (m_h + 1) % N;
                m_h   = -1;
            end
        end
    endtask

    task automatic model_check();
        logic [3:0] eg;
        logic       erv;
        logic [7:0] erd;
        eg = 4'b0000;
        if (m_h >= 0) eg = 4'(1 << m_h);
`ifdef FF_BANK_RDATA_REG_EN
        erv = m_rv;
        erd = m_rd;
`else
        erv = 1'b0;
        erd = m_hold;
        if (m_h >= 0) begin
            if (!we[m_h]) begin
                erv = 1'b1;
                erd = m_mem[int'(addr[m_h*2 +: 2])];
            end
        end
`endif
        check("model_gnt", 32'(gnt), 32'(eg));
        check("model_busy", 32'(busy), 32'(m_h >= 0));
        check("model_rvalid", 32'(rvalid), 32'(erv));
        check("model_rdata", 32'(rdata), 32'(erd));
    endtask

    // One clock: model follows the edge, outputs compared at negedge+1.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        model_check();
    endtask

    // Single unlocked read by requester r; checks data at the right latency
    // and that rdata then holds while rvalid is low.
    task automatic read_word(input int r, input logic [1:0] a, input logic [7:0] exp, input string nm);
        req  = 4'(1 << r);
        lock = 4'b0000;
        set_acc(r, 1'b0, a, 8'h00);
        step();
        check({nm, "_gnt"}, 32'(gnt), 32'(1 << r));
        req = 4'b0000;
`ifndef FF_BANK_RDATA_REG_EN
        check({nm, "_rvalid"}, 32'(rvalid), 32'd1);
        check({nm, "_rdata"}, 32'(rdata), 32'(exp));
`endif
        step();
`ifdef FF_BANK_RDATA_REG_EN
        check({nm, "_rvalid"}, 32'(rvalid), 32'd1);
        check({nm, "_rdata"}, 32'(rdata), 32'(exp));
`endif
        step();
        check({nm, "_rvalid_lo"}, 32'(rvalid), 32'd0);
        check({nm, "_rdata_hold"}, 32'(rdata), 32'(exp));
    endtask

    initial begin
        // Grant vector table: clr, 8 unlocked rounds of req=1111, clr,
        // then lock[0] held for 3 GRANT cycles with req=1001.
        tbl[0] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        for (int j = 0; j < 16; j++) begin
            tbl[1+j] = '{1'b0, 4'b1111, 4'b0000,
                         (j % 2 == 0) ? 4'(1 << ((j/2) % 4)) : 4'b0000,
                         (j % 2 == 0)};
        end
        tbl[17] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[18] = '{1'b0, 4'b1001, 4'b0001, 4'b0001, 1'b1};
        tbl[19] = '{1'b0, 4'b1001, 4'b0001, 4'b0001, 1'b1};
        tbl[20] = '{1'b0, 4'b1001, 4'b0001, 4'b0001, 1'b1};
        tbl[21] = '{1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b0};
        tbl[22] = '{1'b0, 4'b1001, 4'b0000, 4'b1000, 1'b1};
        tbl[23] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};

        m_h = -1; m_ptr = 0; m_hold = 8'h00; m_rv = 1'b0; m_rd = 8'h00;
        for (int k = 0; k < 4; k++) m_mem[k] = 8'h00;

        clr = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        step();
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata", 32'(rdata), 32'd0);

        // Idle with no requests.
        clr = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("idle%0d_gnt", c), 32'(gnt), 32'd0);
            check($sformatf("idle%0d_busy", c), 32'(busy), 32'd0);
            check($sformatf("idle%0d_rvalid", c), 32'(rvalid), 32'd0);
        end

        // Requester 2 writes A5 to word 3, requester 0 reads it back.
        req = 4'b0100;
        set_acc(2, 1'b1, 2'd3, 8'hA5);
        step();
        check("wr_a5_gnt", 32'(gnt), 32'b0100);
        req = 4'b0000;
        step();
        check("wr_a5_idle", 32'(busy), 32'd0);
        set_acc(2, 1'b0, 2'd0, 8'h00);
        read_word(0, 2'd3, 8'hA5, "rd_a5");

        // Requester 1 locked writes 1,2,3 to words 0,1,2 on consecutive cycles.
        req = 4'b0010; lock = 4'b0010;
        set_acc(1, 1'b1, 2'd0, 8'd1);
        step();
        check("lkwr_gnt", 32'(gnt), 32'b0010);
        step();
        check("lkwr_busy", 32'(busy), 32'd1);
        set_acc(1, 1'b1, 2'd1, 8'd2);
        step();
        set_acc(1, 1'b1, 2'd2, 8'd3);
        lock = 4'b0000; req = 4'b0000;
        step();
        check("lkwr_release", 32'(busy), 32'd0);
        set_acc(1, 1'b0, 2'd0, 8'h00);
        read_word(3, 2'd0, 8'd1, "lk_w0");
        read_word(3, 2'd1, 8'd2, "lk_w1");
        read_word(3, 2'd2, 8'd3, "lk_w2");
        read_word(3, 2'd3, 8'hA5, "lk_w3");

        // Reset in the middle of a locked GRANT.
        req = 4'b0010; lock = 4'b0010;
        set_acc(1, 1'b1, 2'd3, 8'h77);
        step();
        check("mid_gnt", 32'(gnt), 32'b0010);
        step();
        check("mid_busy", 32'(busy), 32'd1);
        clr = 1'b1;
        step();
        check("mid_clr_gnt", 32'(gnt), 32'd0);
        check("mid_clr_busy", 32'(busy), 32'd0);
        check("mid_clr_rvalid", 32'(rvalid), 32'd0);
        check("mid_clr_rdata", 32'(rdata), 32'd0);
        clr = 1'b0; req = 4'b0000; lock = 4'b0000;
        set_acc(1, 1'b0, 2'd0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            read_word(k, 2'(k), 8'h00, $sformatf("clr_w%0d", k));
        end

        // Table-driven grant sequences.
        we = 4'b0000; addr = '0; wdata = '0;
        for (int i = 0; i < 24; i++) begin
            clr  = tbl[i].clr;
            req  = tbl[i].req;
            lock = tbl[i].lock;
            step();
            check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].exp_gnt));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
        end
        clr = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            clr   = ($urandom_range(0, 39) == 0);
            req   = 4'($urandom);
            lock  = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000;
            we    = 4'($urandom);
            addr  = 8'($urandom);
            wdata = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ff_bank_arbiter
